// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard slice.
package hazard_pkg;

   // Register fields in a shadow slot are stored at this fixed width and
   // zero-extended from REG_W, so one slot type serves every REG_W <= 8.
   localparam int unsigned SLOT_REG_W = 8;

   // Operand forwarding select encodings driven to the EX muxes.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // Opcodes used by the upstream decoder to derive id_is_load/id_is_store.
   localparam logic [4:0] OP_LD = 5'b01110;
   localparam logic [4:0] OP_ST = 5'b01111;

   // Shadow copy of an in-flight instruction's writer/store information.
   typedef struct packed {
      logic                  valid;
      logic                  wb;
      logic [SLOT_REG_W-1:0] rd;
      logic                  is_load;
      logic                  is_store;
      logic [SLOT_REG_W-1:0] st_reg;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-side request and EX/MEM control bundle of the hazard scoreboard.
interface hazard_scoreboard_unit_if #(
   parameter int unsigned REG_W   = 4,
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned LAT_W   = 4
);
   logic                     id_valid;
   logic [NUM_SRC*REG_W-1:0] id_rs;
   logic [NUM_SRC-1:0]       id_rs_used;
   logic                     id_wb;
   logic [REG_W-1:0]         id_rd;
   logic                     id_is_load;
   logic                     id_is_store;
   logic [LAT_W-1:0]         id_lat;
   logic                     flush;
   logic                     stall;
   logic [NUM_SRC*2-1:0]     fwd_sel_e;
   logic                     fwd_st_m;
   logic                     busy;

   // Decoder / pipeline control side.
   modport master (
      output id_valid, id_rs, id_rs_used, id_wb, id_rd, id_is_load,
             id_is_store, id_lat, flush,
      input  stall, fwd_sel_e, fwd_st_m, busy
   );

   // Hazard unit side.
   modport slave (
      input  id_valid, id_rs, id_rs_used, id_wb, id_rd, id_is_load,
             id_is_store, id_lat, flush,
      output stall, fwd_sel_e, fwd_st_m, busy
   );
endinterface

// File: rtl/hazard_match.sv
// Compares one decode operand against the EX and MEM shadow slots.
// The WB-slot writer has already reached the write-first regfile, so it
// never needs a comparison here.
module hazard_match
   import hazard_pkg::*;
#(
   parameter bit ZERO_REG_EN = 1'b0
) (
   input  logic                  rs_used,
   input  logic [SLOT_REG_W-1:0] rs,
   input  logic                  ex_live,
   input  logic [SLOT_REG_W-1:0] ex_rd,
   input  logic                  ex_is_load,
   input  logic                  mem_live,
   input  logic [SLOT_REG_W-1:0] mem_rd,
   output logic                  match_ex,
   output logic                  match_mem,
   output logic                  load_use
);

   logic rs_ok;

   // Operand qualifies for matching only if read and not the hardwired zero.
   always_comb begin
      rs_ok     = rs_used && !(ZERO_REG_EN && (rs == '0));
      match_ex  = rs_ok && ex_live && (ex_rd == rs);
      match_mem = rs_ok && mem_live && (mem_rd == rs);
      load_use  = match_ex && ex_is_load;
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard: shadows EX/MEM/WB writers, raises decode stall for
// load-use and multi-cycle EX, and registers forwarding selects.
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W       = 4,
   parameter int unsigned NUM_SRC     = 3,
   parameter int unsigned MAX_LAT     = 8,
   parameter int unsigned LAT_W       = $clog2(MAX_LAT + 1),
   parameter bit          ZERO_REG_EN = 1'b0
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_unit_if.slave hs
);

   slot_t                 ex_q, mem_q, wb_q;
   slot_t                 ex_d, mem_d, id_slot;
   logic [LAT_W-1:0]      busy_cnt, cnt_d, lat_eff;
   logic [NUM_SRC*2-1:0]  fwd_sel_q, sel_id, sel_d;
   logic                  fwd_st_q, fwd_st_d;
   logic                  busy_q;
   logic [SLOT_REG_W-1:0] rs_ext [NUM_SRC];
   logic [NUM_SRC-1:0]    match_ex, match_mem, load_use;
   logic                  load_use_any, busy_hold;
   logic                  slot_unused;

   // WB slot is kept for visibility of the retiring writer; nothing reads it.
   assign slot_unused = ^wb_q;

   // Zero-extend each source register address to slot width.
   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         rs_ext[i]              = '0;
         rs_ext[i][REG_W-1:0]   = hs.id_rs[i*REG_W +: REG_W];
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
      hazard_match #(
         .ZERO_REG_EN (ZERO_REG_EN)
      ) u_match (
         .rs_used    (hs.id_rs_used[g]),
         .rs         (rs_ext[g]),
         .ex_live    (ex_q.valid && ex_q.wb),
         .ex_rd      (ex_q.rd),
         .ex_is_load (ex_q.is_load),
         .mem_live   (mem_q.valid && mem_q.wb),
         .mem_rd     (mem_q.rd),
         .match_ex   (match_ex[g]),
         .match_mem  (match_mem[g]),
         .load_use   (load_use[g])
      );
   end

   // Decode-stall request; flush and an empty decode slot never stall.
   always_comb begin
      load_use_any = |load_use;
      busy_hold    = (busy_cnt != '0);
      hs.stall     = hs.id_valid && !hs.flush && (load_use_any || busy_hold);
   end

   // Decode entry as it would be captured into the EX slot, plus its selects.
   always_comb begin
      id_slot                  = SLOT_EMPTY;
      id_slot.valid            = hs.id_valid;
      id_slot.wb               = hs.id_wb;
      id_slot.rd[REG_W-1:0]    = hs.id_rd;
      id_slot.is_load          = hs.id_is_load;
      id_slot.is_store         = hs.id_is_store;
      id_slot.st_reg           = rs_ext[NUM_SRC-1];
      lat_eff = (hs.id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : hs.id_lat;
      sel_id = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (match_ex[i])       sel_id[i*2 +: 2] = FWD_MEM;
         else if (match_mem[i]) sel_id[i*2 +: 2] = FWD_WB;
         else                   sel_id[i*2 +: 2] = FWD_RF;
      end
   end

   // Next-state selection. A multi-cycle op holds EX even when decode is
   // empty, so an idle decode slot cannot push it out before it completes.
   always_comb begin
      ex_d  = id_slot;
      mem_d = ex_q;
      cnt_d = '0;
      sel_d = '0;
      if (hs.flush) begin
         ex_d  = SLOT_EMPTY;
      end else if (busy_hold) begin
         ex_d  = ex_q;
         mem_d = SLOT_EMPTY;
         cnt_d = busy_cnt - LAT_W'(1);
         sel_d = fwd_sel_q;
      end else if (hs.id_valid && load_use_any) begin
         ex_d  = SLOT_EMPTY;
      end else begin
         if (hs.id_valid) begin
            sel_d = sel_id;
            if (lat_eff > LAT_W'(1)) cnt_d = lat_eff - LAT_W'(1);
         end
      end
      fwd_st_d = mem_d.valid && mem_d.is_store &&
                 mem_q.valid && mem_q.wb && mem_q.is_load &&
                 (mem_q.rd == mem_d.st_reg) &&
                 !(ZERO_REG_EN && (mem_d.st_reg == '0));
   end

   // Slot shift, busy counter and registered control outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_q      <= SLOT_EMPTY;
         mem_q     <= SLOT_EMPTY;
         wb_q      <= SLOT_EMPTY;
         busy_cnt  <= '0;
         fwd_sel_q <= '0;
         fwd_st_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         ex_q      <= ex_d;
         mem_q     <= mem_d;
         wb_q      <= mem_q;
         busy_cnt  <= cnt_d;
         fwd_sel_q <= sel_d;
         fwd_st_q  <= fwd_st_d;
         busy_q    <= (cnt_d != '0);
      end
   end

   assign hs.fwd_sel_e = fwd_sel_q;
   assign hs.fwd_st_m  = fwd_st_q;
   assign hs.busy      = busy_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit (REG_W=4, NUM_SRC=3, ZERO_REG_EN=1).
module tb_hazard_scoreboard_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_unit_if #(.REG_W(4), .NUM_SRC(3), .LAT_W(4)) hs ();

   hazard_scoreboard_unit #(
      .REG_W       (4),
      .NUM_SRC     (3),
      .MAX_LAT     (8),
      .LAT_W       (4),
      .ZERO_REG_EN (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hs  (hs.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hs.id_valid    = 1'b0;
      hs.id_rs       = '0;
      hs.id_rs_used  = '0;
      hs.id_wb       = 1'b0;
      hs.id_rd       = '0;
      hs.id_is_load  = 1'b0;
      hs.id_is_store = 1'b0;
      hs.id_lat      = '0;
      hs.flush       = 1'b0;
   endtask

   // issue(rd, wb, ld, st, lat, used, op0, op1, op2)
   task automatic issue(input logic [3:0] rd, input logic wb, input logic ld,
                        input logic st, input logic [3:0] lat, input logic [2:0] used,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      hs.id_valid    = 1'b1;
      hs.id_rd       = rd;
      hs.id_wb       = wb;
      hs.id_is_load  = ld;
      hs.id_is_store = st;
      hs.id_lat      = lat;
      hs.id_rs_used  = used;
      hs.id_rs       = {c, b, a};
      hs.flush       = 1'b0;
   endtask

   task automatic drain();
      idle();
      tick(); tick(); tick();
   endtask

   initial begin
      idle();
      tick(); tick();
      chk("rst_stall", 32'(hs.stall), 32'h0);
      chk("rst_fwd",   32'(hs.fwd_sel_e), 32'h0);
      chk("rst_st",    32'(hs.fwd_st_m), 32'h0);
      chk("rst_busy",  32'(hs.busy), 32'h0);
      rst = 1'b1;
      tick();

      // ALU back-to-back and one-apart forwarding
      issue(4'd3, 1, 0, 0, 4'd1, 3'b011, 4'd1, 4'd2, 4'd0);  // add r3
      #1 chk("alu0_stall", 32'(hs.stall), 32'h0);
      tick();
      issue(4'd4, 1, 0, 0, 4'd1, 3'b011, 4'd3, 4'd2, 4'd0);  // sub r4 <- r3,r2
      #1 chk("alu1_stall", 32'(hs.stall), 32'h0);
      tick();
      chk("alu1_fwd_ex", 32'(hs.fwd_sel_e), 32'h02);
      issue(4'd6, 1, 0, 0, 4'd1, 3'b011, 4'd8, 4'd9, 4'd0);  // unrelated
      #1;
      tick();
      chk("alu2_fwd_none", 32'(hs.fwd_sel_e), 32'h00);
      issue(4'd10, 1, 0, 0, 4'd1, 3'b011, 4'd4, 4'd3, 4'd0); // r4 in MEM, r3 in WB
      #1 chk("alu3_stall", 32'(hs.stall), 32'h0);
      tick();
      chk("alu3_fwd_mem", 32'(hs.fwd_sel_e), 32'h01);
      idle();
      tick();
      chk("bubble_fwd", 32'(hs.fwd_sel_e), 32'h00);
      drain();

      // load-use
      issue(4'd5, 1, 1, 0, 4'd1, 3'b001, 4'd1, 4'd0, 4'd0);  // ld r5
      #1;
      tick();
      issue(4'd1, 1, 0, 0, 4'd1, 3'b011, 4'd5, 4'd2, 4'd0);  // add r1 <- r5,r2
      #1 chk("lu_stall_on", 32'(hs.stall), 32'h1);
      tick();
      chk("lu_bubble_fwd", 32'(hs.fwd_sel_e), 32'h00);
      #1 chk("lu_stall_off", 32'(hs.stall), 32'h0);
      tick();
      chk("lu_fwd_wb", 32'(hs.fwd_sel_e), 32'h01);
      drain();

      // multi-cycle EX, latency 4
      issue(4'd9, 1, 0, 0, 4'd4, 3'b011, 4'd1, 4'd2, 4'd0);  // mul r9
      #1;
      tick();
      chk("mc_busy0", 32'(hs.busy), 32'h1);
      issue(4'd10, 1, 0, 0, 4'd1, 3'b011, 4'd9, 4'd3, 4'd0); // dep on r9
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("mc_stall%0d", k), 32'(hs.stall), 32'h1);
         tick();
         chk($sformatf("mc_busy%0d", k + 1), 32'(hs.busy), (k < 2) ? 32'h1 : 32'h0);
      end
      #1 chk("mc_release", 32'(hs.stall), 32'h0);
      tick();
      chk("mc_fwd_ex", 32'(hs.fwd_sel_e), 32'h02);
      drain();

      // ld r7 then st r7 with data read in EX: stall, then WB select on op2
      issue(4'd7, 1, 1, 0, 4'd1, 3'b001, 4'd1, 4'd0, 4'd0);
      #1;
      tick();
      issue(4'd0, 0, 0, 1, 4'd1, 3'b101, 4'd1, 4'd0, 4'd7);
      #1 chk("st_lu_stall", 32'(hs.stall), 32'h1);
      tick();
      #1 chk("st_lu_release", 32'(hs.stall), 32'h0);
      tick();
      chk("st_lu_fwd_op2", 32'(hs.fwd_sel_e), 32'h10);
      idle();
      tick();
      chk("st_lu_no_stfwd", 32'(hs.fwd_st_m), 32'h0);
      drain();

      // ld r7 then st r7 with data taken in MEM: no stall, fwd_st_m
      issue(4'd7, 1, 1, 0, 4'd1, 3'b001, 4'd1, 4'd0, 4'd0);
      #1;
      tick();
      issue(4'd0, 0, 0, 1, 4'd1, 3'b001, 4'd1, 4'd0, 4'd7);
      #1 chk("st_m_stall", 32'(hs.stall), 32'h0);
      tick();
      idle();
      tick();
      chk("st_m_fwd_on", 32'(hs.fwd_st_m), 32'h1);
      tick();
      chk("st_m_fwd_off", 32'(hs.fwd_st_m), 32'h0);
      drain();

      // flush during load-use stall
      issue(4'd5, 1, 1, 0, 4'd1, 3'b001, 4'd1, 4'd0, 4'd0);
      #1;
      tick();
      issue(4'd11, 1, 0, 0, 4'd1, 3'b001, 4'd5, 4'd0, 4'd0);
      hs.flush = 1'b1;
      #1 chk("fl_lu_stall", 32'(hs.stall), 32'h0);
      tick();
      chk("fl_lu_fwd", 32'(hs.fwd_sel_e), 32'h00);
      issue(4'd12, 1, 0, 0, 4'd1, 3'b011, 4'd5, 4'd11, 4'd0);
      #1 chk("fl_lu_next_stall", 32'(hs.stall), 32'h0);
      tick();
      chk("fl_lu_next_fwd", 32'(hs.fwd_sel_e), 32'h01);
      drain();

      // flush while busy_cnt == 2
      issue(4'd12, 1, 0, 0, 4'd4, 3'b011, 4'd1, 4'd2, 4'd0);
      #1;
      tick();
      issue(4'd13, 1, 0, 0, 4'd1, 3'b001, 4'd12, 4'd0, 4'd0);
      #1;
      tick();
      hs.flush = 1'b1;
      #1 chk("fl_busy_stall", 32'(hs.stall), 32'h0);
      tick();
      chk("fl_busy_busy", 32'(hs.busy), 32'h0);
      chk("fl_busy_fwd", 32'(hs.fwd_sel_e), 32'h00);
      issue(4'd14, 1, 0, 0, 4'd1, 3'b011, 4'd12, 4'd13, 4'd0);
      #1 chk("fl_busy_next_stall", 32'(hs.stall), 32'h0);
      tick();
      chk("fl_busy_next_fwd", 32'(hs.fwd_sel_e), 32'h01);
      drain();

      // register 0 never forwards or stalls
      issue(4'd0, 1, 1, 0, 4'd1, 3'b001, 4'd1, 4'd0, 4'd0);  // ld r0
      #1;
      tick();
      issue(4'd2, 1, 0, 0, 4'd1, 3'b011, 4'd0, 4'd0, 4'd0);
      #1 chk("r0_stall", 32'(hs.stall), 32'h0);
      tick();
      chk("r0_fwd", 32'(hs.fwd_sel_e), 32'h00);
      drain();

      // synchronous reset mid-busy
      issue(4'd3, 1, 0, 0, 4'd1, 3'b011, 4'd1, 4'd2, 4'd0);
      #1;
      tick();
      issue(4'd14, 1, 0, 0, 4'd5, 3'b001, 4'd3, 4'd0, 4'd0);
      #1;
      tick();
      chk("rm_pre_fwd",  32'(hs.fwd_sel_e), 32'h02);
      chk("rm_pre_busy", 32'(hs.busy), 32'h1);
      issue(4'd15, 1, 0, 0, 4'd1, 3'b001, 4'd14, 4'd0, 4'd0);
      #1 chk("rm_pre_stall", 32'(hs.stall), 32'h1);
      rst = 1'b0;
      tick();
      chk("rm_busy",  32'(hs.busy), 32'h0);
      chk("rm_fwd",   32'(hs.fwd_sel_e), 32'h00);
      chk("rm_st",    32'(hs.fwd_st_m), 32'h0);
      chk("rm_stall", 32'(hs.stall), 32'h0);
      rst = 1'b1;
      tick();
      chk("rm_after_fwd", 32'(hs.fwd_sel_e), 32'h00);
      chk("rm_after_busy", 32'(hs.busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
